// File: rtl/spiking_neuron_two_in.sv
// Two-input integrate-and-fire neuron: weighted spikes accumulate into a saturating
// membrane potential; crossing threshold emits a one-cycle registered spike and clears it.
module spiking_neuron_two_in #(
  parameter int unsigned NEURON_LEVEL = 0,
  parameter int unsigned NEURON_ID    = 0,
  parameter bit          SILENT       = 1'b1,
  parameter int unsigned INT_WIDTH    = 4,
  parameter int unsigned IN1_WEIGHT   = 7,
  parameter int unsigned IN2_WEIGHT   = 7,
  parameter int unsigned THRESHOLD    = 8,
  parameter int unsigned LEAK         = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic in1,
  input  logic in2,
  output logic out
);

  // Two guard bits so pot + both weights can never wrap before saturation.
  localparam int unsigned SW = INT_WIDTH + 2;

  localparam logic [INT_WIDTH-1:0] POT_MAX = '1;
  localparam logic [INT_WIDTH-1:0] THR     = INT_WIDTH'(THRESHOLD);
  localparam logic [INT_WIDTH-1:0] LEAK_N  = INT_WIDTH'(LEAK);
  localparam logic [SW-1:0]        W1_X    = SW'(IN1_WEIGHT);
  localparam logic [SW-1:0]        W2_X    = SW'(IN2_WEIGHT);
  localparam logic [SW-1:0]        MAX_X   = SW'(POT_MAX);
  localparam logic [SW-1:0]        LEAK_X  = SW'(LEAK);

  logic [INT_WIDTH-1:0] pot_q, pot_d;
  logic                 out_q, out_d;
  logic                 fire;
  logic [SW-1:0]        pot_x;
  logic [SW-1:0]        sum;

  always_comb begin
    fire  = (pot_q >= THR);
    pot_x = SW'(pot_q);
    sum   = pot_x + (in1 ? W1_X : '0) + (in2 ? W2_X : '0);
    out_d = fire;
    pot_d = pot_q;
    if (fire) begin
      // Refractory cycle: inputs arriving while firing are dropped.
      pot_d = '0;
    end else if (in1 || in2) begin
      pot_d = (sum > MAX_X) ? POT_MAX : sum[INT_WIDTH-1:0];
    end else begin
      pot_d = (pot_x > LEAK_X) ? (pot_q - LEAK_N) : '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pot_q <= '0;
      out_q <= 1'b0;
    end else begin
      pot_q <= pot_d;
      out_q <= out_d;
    end
  end

  assign out = out_q;

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!SILENT && rst && out_q)
      $display("L%0d N%0d spike %0t", NEURON_LEVEL, NEURON_ID, $time);
  end
`endif

endmodule

// File: tb/tb_spiking_neuron_two_in.sv
// Directed bench for spiking_neuron_two_in: arithmetic reference model checked every
// cycle, plus hand-computed pot/out values for each scenario.
module tb_spiking_neuron_two_in;

  localparam int INT_WIDTH = 4;
  localparam int W1        = 7;
  localparam int W2        = 7;
  localparam int THRESHOLD = 8;
  localparam int LEAK      = 0;
  localparam int POT_MAX   = (1 << INT_WIDTH) - 1;

  logic clk;
  logic rst;
  logic in1;
  logic in2;
  logic out;

  int checks;
  int errors;

  spiking_neuron_two_in #(
    .NEURON_LEVEL(0), .NEURON_ID(0), .SILENT(1'b1), .INT_WIDTH(INT_WIDTH),
    .IN1_WEIGHT(W1), .IN2_WEIGHT(W2), .THRESHOLD(THRESHOLD), .LEAK(LEAK)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in1(in1),
    .in2(in2),
    .out(out)
  );

  // clock / reset
  initial clk = 1'b0;
  always #10 clk = ~clk;

  // reference model: potential and spike as plain integers
  int m_pot;
  int m_out;

  function automatic int next_pot(int p, bit a, bit b);
    int s;
    if (p >= THRESHOLD) return 0;
    if (a || b) begin
      s = p + (a ? W1 : 0) + (b ? W2 : 0);
      return (s > POT_MAX) ? POT_MAX : s;
    end
    return (p > LEAK) ? p - LEAK : 0;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_pot <= 0;
      m_out <= 0;
    end else begin
      m_out <= (m_pot >= THRESHOLD) ? 1 : 0;
      m_pot <= next_pot(m_pot, in1, in2);
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // per-cycle compare against the model
  always @(negedge clk) begin
    check("model_out", int'(out), m_out);
    check("model_pot", int'(dut.pot_q), m_pot);
  end

  // driver: apply inputs, let one rising edge sample them, return just after it
  task automatic step(input bit a, input bit b);
    in1 = a;
    in2 = b;
    @(posedge clk);
    #2;
  endtask

  task automatic expect_now(input string name, input int pot_exp, input int out_exp);
    check({name, "_pot"}, int'(dut.pot_q), pot_exp);
    check({name, "_out"}, int'(out), out_exp);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    in1 = 1'b0;
    in2 = 1'b0;

    // 1. reset held with inputs toggling
    for (int i = 0; i < 6; i++) begin
      step(i[0], ~i[0]);
      expect_now("reset_hold", 0, 0);
    end
    step(1'b1, 1'b1);
    expect_now("reset_both", 0, 0);
    in1 = 1'b0;
    in2 = 1'b0;
    rst = 1'b1;

    // 2. sequential inputs
    step(1'b1, 1'b0);  expect_now("seq_in1", 7, 0);
    step(1'b0, 1'b1);  expect_now("seq_in2", 14, 0);
    step(1'b0, 1'b0);  expect_now("seq_fire", 0, 1);
    step(1'b0, 1'b0);  expect_now("seq_after", 0, 0);

    // 3. simultaneous inputs
    step(1'b1, 1'b1);  expect_now("sim_both", 14, 0);
    step(1'b0, 1'b0);  expect_now("sim_fire", 0, 1);
    step(1'b0, 1'b0);  expect_now("sim_after", 0, 0);

    // 4. single input persists without leak, later in2 fires
    step(1'b1, 1'b0);  expect_now("single_in1", 7, 0);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0);
      expect_now("single_hold", 7, 0);
    end
    step(1'b0, 1'b1);  expect_now("single_in2", 14, 0);
    step(1'b0, 1'b0);  expect_now("single_fire", 0, 1);
    step(1'b0, 1'b0);  expect_now("single_after", 0, 0);

    // 5. saturation from pot=7, then refractory alternation with both held
    step(1'b1, 1'b0);  expect_now("sat_pre", 7, 0);
    step(1'b1, 1'b1);  expect_now("sat_clip", 15, 0);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1);  expect_now("refr_fire", 0, 1);
      step(1'b1, 1'b1);  expect_now("refr_acc", 14, 0);
    end
    step(1'b0, 1'b0);  expect_now("refr_last", 0, 1);
    step(1'b0, 1'b0);  expect_now("refr_idle", 0, 0);

    // 6. asynchronous reset mid-cycle with a fire pending
    step(1'b1, 1'b1);  expect_now("arst_pre", 14, 0);
    in1 = 1'b0;
    in2 = 1'b0;
    #3 rst = 1'b0;
    #1 expect_now("arst_now", 0, 0);
    @(posedge clk);
    #2 expect_now("arst_held", 0, 0);
    #3 rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0);
      expect_now("arst_after", 0, 0);
    end

    // spike is still produced normally after the reset
    step(1'b1, 1'b1);  expect_now("post_acc", 14, 0);
    step(1'b0, 1'b0);  expect_now("post_fire", 0, 1);
    step(1'b0, 1'b0);  expect_now("post_idle", 0, 0);

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
